// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage: one outstanding I-cache request, redirect handling, decode hand-off
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        to_cache_inst_req_valid,
    output logic [31:0] to_cache_inst_req_addr,
    input  logic        from_cache_inst_req_ready,
    input  logic        from_cache_rsp_valid,
    input  logic [31:0] from_cache_rsp_data,
    output logic        to_cache_rsp_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        to_id_valid,
    output logic [31:0] to_id_pc,
    output logic [31:0] to_id_inst,
    input  logic        from_id_ready
);

    typedef enum logic [1:0] {
        INIT = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'h3;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        discard;
    logic        discard_next;
    logic        capture;
    logic [31:0] redirect_target;

    assign redirect_target = redirect_pc & ~32'h3;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    // Redirect is checked first in every branch so it always wins, except in INIT.
    always_comb begin
        state_next   = state;
        pc_next      = pc;
        discard_next = discard;
        capture      = 1'b0;
        case (state)
            INIT: begin
                state_next = REQ;
            end
            REQ: begin
                if (redirect_valid) begin
                    pc_next = redirect_target;
                end else if (from_cache_inst_req_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (from_cache_rsp_valid) begin
                    if (discard || redirect_valid) begin
                        discard_next = 1'b0;
                        state_next   = REQ;
                        if (redirect_valid) begin
                            pc_next = redirect_target;
                        end
                    end else begin
                        capture    = 1'b1;
                        state_next = HOLD;
                    end
                end else if (redirect_valid) begin
                    // The in-flight word belongs to the old path; drop it when it lands.
                    pc_next      = redirect_target;
                    discard_next = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_next    = redirect_target;
                    state_next = REQ;
                end else if (from_id_ready) begin
                    pc_next    = pc + 32'd4;
                    state_next = REQ;
                end
            end
            default: begin
                state_next = INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC_ALIGNED;
            discard    <= 1'b0;
            to_id_pc   <= 32'h0;
            to_id_inst <= 32'h0;
        end else begin
            pc      <= pc_next;
            discard <= discard_next;
            if (capture) begin
                to_id_inst <= from_cache_rsp_data;
                to_id_pc   <= pc;
            end
        end
    end

    // Valids are also gated by rst so nothing leaks out in the first reset cycle.
    always_comb begin
        to_cache_inst_req_addr  = pc;
        to_cache_inst_req_valid = ~rst & (state == REQ) & ~redirect_valid;
        to_cache_rsp_ready      = ~rst & (state == WAIT);
        to_id_valid             = ~rst & (state == HOLD) & ~redirect_valid;
    end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - self-checking bench for inst_fetch with a behavioural I-cache and fetch-stream model
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        to_cache_inst_req_valid;
    logic [31:0] to_cache_inst_req_addr;
    logic        from_cache_inst_req_ready;
    logic        from_cache_rsp_valid;
    logic [31:0] from_cache_rsp_data;
    logic        to_cache_rsp_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        to_id_valid;
    logic [31:0] to_id_pc;
    logic [31:0] to_id_inst;
    logic        from_id_ready;

    int n_pass;
    int n_total;

    // I-cache behaviour: accepts with ready_pct probability, answers after delay_min..delay_max cycles
    int          ready_pct;
    int          delay_min;
    int          delay_max;
    logic        c_busy;
    logic [31:0] c_addr;
    int          c_cnt;

    inst_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .to_cache_inst_req_valid   (to_cache_inst_req_valid),
        .to_cache_inst_req_addr    (to_cache_inst_req_addr),
        .from_cache_inst_req_ready (from_cache_inst_req_ready),
        .from_cache_rsp_valid      (from_cache_rsp_valid),
        .from_cache_rsp_data       (from_cache_rsp_data),
        .to_cache_rsp_ready        (to_cache_rsp_ready),
        .redirect_valid            (redirect_valid),
        .redirect_pc               (redirect_pc),
        .to_id_valid               (to_id_valid),
        .to_id_pc                  (to_id_pc),
        .to_id_inst                (to_id_inst),
        .from_id_ready             (from_id_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mkdata(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic tick_pre();
        @(negedge clk);
        from_cache_inst_req_ready = (int'($urandom_range(99)) < ready_pct);
        from_cache_rsp_valid      = c_busy && (c_cnt == 0);
        from_cache_rsp_data       = from_cache_rsp_valid ? mkdata(c_addr) : $urandom;
    endtask

    task automatic cache_update();
        if (rst) begin
            c_busy = 1'b0;
        end else if (from_cache_rsp_valid && to_cache_rsp_ready) begin
            c_busy = 1'b0;
        end else if (to_cache_inst_req_valid && from_cache_inst_req_ready) begin
            c_busy = 1'b1;
            c_addr = to_cache_inst_req_addr;
            c_cnt  = int'($urandom_range(delay_max, delay_min));
        end else if (c_busy && c_cnt > 0) begin
            c_cnt--;
        end
    endtask

    task automatic apply_reset();
        for (int i = 0; i < 2; i++) begin
            tick_pre(); rst = 1'b1; redirect_valid = 1'b0; from_id_ready = 1'b1;
            #1; cache_update();
        end
        tick_pre(); rst = 1'b0;
        #1; cache_update();
    endtask

    task automatic test_reset();
        ready_pct = 100; delay_min = 0; delay_max = 0;
        tick_pre(); rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h500; from_id_ready = 1'b1;
        #1;
        n_total++; if (to_cache_inst_req_valid !== 1'b0) $display("FAIL rst_req_valid: got %b expected 0", to_cache_inst_req_valid); else n_pass++;
        n_total++; if (to_cache_rsp_ready !== 1'b0) $display("FAIL rst_rsp_ready: got %b expected 0", to_cache_rsp_ready); else n_pass++;
        n_total++; if (to_id_valid !== 1'b0) $display("FAIL rst_id_valid: got %b expected 0", to_id_valid); else n_pass++;
        cache_update();
        tick_pre();
        #1;
        n_total++; if (to_id_pc !== 32'h0) $display("FAIL rst_id_pc: got %h expected 0", to_id_pc); else n_pass++;
        n_total++; if (to_id_inst !== 32'h0) $display("FAIL rst_id_inst: got %h expected 0", to_id_inst); else n_pass++;
        cache_update();
        tick_pre(); rst = 1'b0;
        #1;
        n_total++; if (to_cache_inst_req_valid !== 1'b0) $display("FAIL init_req_valid: got %b expected 0", to_cache_inst_req_valid); else n_pass++;
        n_total++; if (to_cache_rsp_ready !== 1'b0) $display("FAIL init_rsp_ready: got %b expected 0", to_cache_rsp_ready); else n_pass++;
        cache_update();
        tick_pre(); redirect_valid = 1'b0;
        #1;
        n_total++; if (to_cache_inst_req_valid !== 1'b1) $display("FAIL first_req_valid: got %b expected 1", to_cache_inst_req_valid); else n_pass++;
        n_total++; if (to_cache_inst_req_addr !== RESET_PC) $display("FAIL first_req_addr: got %h expected %h", to_cache_inst_req_addr, RESET_PC); else n_pass++;
        cache_update();
    endtask

    task automatic test_straight_line();
        logic [31:0] reqs[$];
        logic [31:0] ids_pc[$];
        logic [31:0] ids_inst[$];
        ready_pct = 100; delay_min = 0; delay_max = 0;
        apply_reset();
        for (int i = 0; i < 40 && ids_pc.size() < 3; i++) begin
            tick_pre(); from_id_ready = 1'b1;
            #1;
            if (to_cache_inst_req_valid && from_cache_inst_req_ready) reqs.push_back(to_cache_inst_req_addr);
            if (to_id_valid) begin ids_pc.push_back(to_id_pc); ids_inst.push_back(to_id_inst); end
            cache_update();
        end
        n_total++;
        if (ids_pc.size() < 3 || reqs.size() < 3) begin
            $display("FAIL straight_count: got %0d deliveries %0d requests expected 3", ids_pc.size(), reqs.size());
        end else begin
            n_pass++;
            for (int i = 0; i < 3; i++) begin
                n_total++; if (reqs[i] !== 32'(i * 4)) $display("FAIL straight_req_addr%0d: got %h expected %h", i, reqs[i], 32'(i * 4)); else n_pass++;
                n_total++; if (ids_pc[i] !== 32'(i * 4)) $display("FAIL straight_id_pc%0d: got %h expected %h", i, ids_pc[i], 32'(i * 4)); else n_pass++;
                n_total++; if (ids_inst[i] !== mkdata(32'(i * 4))) $display("FAIL straight_id_inst%0d: got %h expected %h", i, ids_inst[i], mkdata(32'(i * 4))); else n_pass++;
            end
        end
    endtask

    task automatic test_backpressure();
        logic        found;
        logic [31:0] hpc;
        logic [31:0] hinst;
        ready_pct = 100; delay_min = 0; delay_max = 0;
        apply_reset();
        found = 1'b0; hpc = 32'h0; hinst = 32'h0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick_pre(); from_id_ready = 1'b0;
            #1;
            if (to_id_valid) begin found = 1'b1; hpc = to_id_pc; hinst = to_id_inst; end
            cache_update();
        end
        n_total++; if (!found) $display("FAIL bp_hold_reached: got 0 expected 1"); else n_pass++;
        n_total++; if (hinst !== mkdata(32'h0)) $display("FAIL bp_first_inst: got %h expected %h", hinst, mkdata(32'h0)); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            tick_pre();
            #1;
            n_total++; if (to_id_valid !== 1'b1) $display("FAIL bp_valid%0d: got %b expected 1", i, to_id_valid); else n_pass++;
            n_total++; if (to_id_pc !== 32'h0) $display("FAIL bp_pc%0d: got %h expected 0", i, to_id_pc); else n_pass++;
            n_total++; if (to_id_inst !== hinst) $display("FAIL bp_inst%0d: got %h expected %h", i, to_id_inst, hinst); else n_pass++;
            n_total++; if (to_cache_inst_req_valid !== 1'b0) $display("FAIL bp_no_req%0d: got %b expected 0", i, to_cache_inst_req_valid); else n_pass++;
            cache_update();
        end
        tick_pre(); from_id_ready = 1'b1;
        #1; cache_update();
        tick_pre();
        #1;
        n_total++; if (to_cache_inst_req_valid !== 1'b1 || to_cache_inst_req_addr !== 32'h4) $display("FAIL bp_next_req: got %b/%h expected 1/00000004", to_cache_inst_req_valid, to_cache_inst_req_addr); else n_pass++;
        cache_update();
    endtask

    task automatic test_redirect_wait();
        int          n_bad;
        logic        found;
        logic [31:0] naddr;
        ready_pct = 100; delay_min = 3; delay_max = 3;
        apply_reset();
        tick_pre(); redirect_valid = 1'b1; redirect_pc = 32'h10;
        #1; cache_update();
        tick_pre(); redirect_valid = 1'b0;
        #1;
        n_total++; if (to_cache_inst_req_valid !== 1'b1 || to_cache_inst_req_addr !== 32'h10) $display("FAIL rw_req10: got %b/%h expected 1/00000010", to_cache_inst_req_valid, to_cache_inst_req_addr); else n_pass++;
        cache_update();
        tick_pre(); redirect_valid = 1'b1; redirect_pc = 32'h200;
        #1;
        n_total++; if (to_cache_rsp_ready !== 1'b1) $display("FAIL rw_rsp_ready: got %b expected 1", to_cache_rsp_ready); else n_pass++;
        cache_update();
        n_bad = 0; found = 1'b0; naddr = 32'h0;
        delay_min = 0; delay_max = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick_pre(); redirect_valid = 1'b0;
            #1;
            if (to_id_valid) n_bad++;
            if (to_cache_inst_req_valid) begin found = 1'b1; naddr = to_cache_inst_req_addr; end
            cache_update();
        end
        n_total++; if (n_bad != 0) $display("FAIL rw_dropped: got %0d deliveries expected 0", n_bad); else n_pass++;
        n_total++; if (!found || naddr !== 32'h200) $display("FAIL rw_next_req: got %b/%h expected 1/00000200", found, naddr); else n_pass++;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick_pre();
            #1;
            if (to_id_valid) begin
                found = 1'b1;
                n_total++; if (to_id_pc !== 32'h200 || to_id_inst !== mkdata(32'h200)) $display("FAIL rw_deliver: got %h/%h expected 00000200/%h", to_id_pc, to_id_inst, mkdata(32'h200)); else n_pass++;
            end
            cache_update();
        end
        n_total++; if (!found) $display("FAIL rw_deliver_timeout: got 0 expected 1"); else n_pass++;
    endtask

    task automatic test_redirect_hold();
        logic found;
        ready_pct = 100; delay_min = 0; delay_max = 0;
        apply_reset();
        tick_pre(); redirect_valid = 1'b1; redirect_pc = 32'h20; from_id_ready = 1'b0;
        #1; cache_update();
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick_pre(); redirect_valid = 1'b0;
            #1;
            if (to_id_valid) found = 1'b1;
            cache_update();
        end
        n_total++; if (!found || to_id_pc !== 32'h20) $display("FAIL rh_held: got %b/%h expected 1/00000020", found, to_id_pc); else n_pass++;
        tick_pre(); from_id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
        #1;
        n_total++; if (to_id_valid !== 1'b0) $display("FAIL rh_valid_masked: got %b expected 0", to_id_valid); else n_pass++;
        cache_update();
        tick_pre(); redirect_valid = 1'b0;
        #1;
        n_total++; if (to_cache_inst_req_valid !== 1'b1 || to_cache_inst_req_addr !== 32'h100) $display("FAIL rh_next_req: got %b/%h expected 1/00000100", to_cache_inst_req_valid, to_cache_inst_req_addr); else n_pass++;
        cache_update();
    endtask

    task automatic test_wrap();
        logic found;
        ready_pct = 100; delay_min = 0; delay_max = 0;
        apply_reset();
        tick_pre(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE; from_id_ready = 1'b1;
        #1; cache_update();
        tick_pre(); redirect_valid = 1'b0;
        #1;
        n_total++; if (to_cache_inst_req_valid !== 1'b1 || to_cache_inst_req_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_req: got %b/%h expected 1/fffffffc", to_cache_inst_req_valid, to_cache_inst_req_addr); else n_pass++;
        cache_update();
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick_pre();
            #1;
            if (to_id_valid) begin
                found = 1'b1;
                n_total++; if (to_id_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_id_pc: got %h expected fffffffc", to_id_pc); else n_pass++;
            end
            cache_update();
        end
        n_total++; if (!found) $display("FAIL wrap_deliver_timeout: got 0 expected 1"); else n_pass++;
        tick_pre();
        #1;
        n_total++; if (to_cache_inst_req_valid !== 1'b1 || to_cache_inst_req_addr !== 32'h0) $display("FAIL wrap_next_req: got %b/%h expected 1/00000000", to_cache_inst_req_valid, to_cache_inst_req_addr); else n_pass++;
        cache_update();
    endtask

    task automatic test_reset_mid_wait();
        ready_pct = 100; delay_min = 5; delay_max = 5;
        apply_reset();
        tick_pre(); redirect_valid = 1'b1; redirect_pc = 32'h40;
        #1; cache_update();
        tick_pre(); redirect_valid = 1'b0;
        #1;
        n_total++; if (to_cache_inst_req_valid !== 1'b1 || to_cache_inst_req_addr !== 32'h40) $display("FAIL rmw_req: got %b/%h expected 1/00000040", to_cache_inst_req_valid, to_cache_inst_req_addr); else n_pass++;
        cache_update();
        tick_pre();
        #1;
        n_total++; if (to_cache_rsp_ready !== 1'b1) $display("FAIL rmw_waiting: got %b expected 1", to_cache_rsp_ready); else n_pass++;
        cache_update();
        tick_pre(); rst = 1'b1;
        #1;
        n_total++; if ({to_cache_inst_req_valid, to_cache_rsp_ready, to_id_valid} !== 3'b000) $display("FAIL rmw_in_rst: got %b expected 000", {to_cache_inst_req_valid, to_cache_rsp_ready, to_id_valid}); else n_pass++;
        cache_update();
        tick_pre(); rst = 1'b0;
        #1;
        n_total++; if ({to_cache_inst_req_valid, to_cache_rsp_ready, to_id_valid} !== 3'b000) $display("FAIL rmw_after_rst: got %b expected 000", {to_cache_inst_req_valid, to_cache_rsp_ready, to_id_valid}); else n_pass++;
        cache_update();
        tick_pre();
        #1;
        n_total++; if (to_cache_inst_req_valid !== 1'b1 || to_cache_inst_req_addr !== RESET_PC) $display("FAIL rmw_restart: got %b/%h expected 1/%h", to_cache_inst_req_valid, to_cache_inst_req_addr, RESET_PC); else n_pass++;
        cache_update();
    endtask

    // Fetch-stream model: the fetcher owns at most one request or one held word at a time,
    // and the next address is RESET_PC, the last redirect target, or the last consumed pc + 4.
    task automatic test_random();
        logic        m_init, m_out, m_killed, m_pend;
        logic [31:0] m_pc, m_oaddr, m_ppc, m_pinst;
        logic        exp_req, exp_rdy, exp_idv;
        ready_pct = 70; delay_min = 0; delay_max = 3;
        apply_reset();
        m_init = 1'b0; m_out = 1'b0; m_killed = 1'b0; m_pend = 1'b0;
        m_pc = RESET_PC; m_oaddr = 32'h0; m_ppc = 32'h0; m_pinst = 32'h0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick_pre();
            rst            = ($urandom_range(199) == 0);
            redirect_valid = ($urandom_range(7) == 0);
            redirect_pc    = $urandom;
            from_id_ready  = ($urandom_range(2) != 0);
            #1;
            exp_req = !rst && !m_init && !m_out && !m_pend && !redirect_valid;
            exp_rdy = !rst && !m_init && m_out;
            exp_idv = !rst && !m_init && m_pend && !redirect_valid;
            n_total++; if (to_cache_inst_req_valid !== exp_req) $display("FAIL rnd_req_valid@%0d: got %b expected %b", cyc, to_cache_inst_req_valid, exp_req); else n_pass++;
            n_total++; if (to_cache_rsp_ready !== exp_rdy) $display("FAIL rnd_rsp_ready@%0d: got %b expected %b", cyc, to_cache_rsp_ready, exp_rdy); else n_pass++;
            n_total++; if (to_id_valid !== exp_idv) $display("FAIL rnd_id_valid@%0d: got %b expected %b", cyc, to_id_valid, exp_idv); else n_pass++;
            if (exp_req) begin
                n_total++; if (to_cache_inst_req_addr !== m_pc) $display("FAIL rnd_req_addr@%0d: got %h expected %h", cyc, to_cache_inst_req_addr, m_pc); else n_pass++;
            end
            if (exp_idv) begin
                n_total++; if (to_id_pc !== m_ppc || to_id_inst !== m_pinst) $display("FAIL rnd_id_word@%0d: got %h/%h expected %h/%h", cyc, to_id_pc, to_id_inst, m_ppc, m_pinst); else n_pass++;
            end
            if (rst) begin
                m_init = 1'b1; m_out = 1'b0; m_pend = 1'b0; m_pc = RESET_PC;
            end else if (m_init) begin
                m_init = 1'b0;
            end else if (m_out) begin
                if (from_cache_rsp_valid) begin
                    m_out = 1'b0;
                    if (!m_killed && !redirect_valid) begin
                        m_pend = 1'b1; m_ppc = m_oaddr; m_pinst = mkdata(m_oaddr);
                    end
                end else if (redirect_valid) begin
                    m_killed = 1'b1;
                end
                if (redirect_valid) m_pc = redirect_pc & ~32'h3;
            end else if (m_pend) begin
                if (redirect_valid) begin
                    m_pend = 1'b0; m_pc = redirect_pc & ~32'h3;
                end else if (from_id_ready) begin
                    m_pend = 1'b0; m_pc = m_ppc + 32'd4;
                end
            end else begin
                if (redirect_valid) begin
                    m_pc = redirect_pc & ~32'h3;
                end else if (from_cache_inst_req_ready) begin
                    m_out = 1'b1; m_killed = 1'b0; m_oaddr = m_pc;
                end
            end
            cache_update();
        end
        tick_pre(); rst = 1'b0; redirect_valid = 1'b0;
        #1; cache_update();
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; from_id_ready = 1'b1;
        from_cache_inst_req_ready = 1'b0; from_cache_rsp_valid = 1'b0; from_cache_rsp_data = 32'h0;
        ready_pct = 100; delay_min = 0; delay_max = 0;
        c_busy = 1'b0; c_addr = 32'h0; c_cnt = 0;
        test_reset();
        test_straight_line();
        test_backpressure();
        test_redirect_wait();
        test_redirect_hold();
        test_wrap();
        test_reset_mid_wait();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
